// File: rtl/msu_sq_sequencer_if.sv
// Job, datapath and result handshake bundle for the squaring-unit sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's.
interface msu_sq_sequencer_if #(
   parameter int unsigned TotalBits = 289,
   parameter int unsigned IterBits  = 64
);

   logic                 start_valid_i;
   logic                 start_ready_o;
   logic [TotalBits-1:0] sq_in_i;
   logic [IterBits-1:0]  iters_i;
   logic                 abort_i;
   logic                 sq_start_o;
   logic [TotalBits-1:0] sq_data_o;
   logic                 sq_valid_i;
   logic [TotalBits-1:0] sq_result_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [TotalBits-1:0] sq_out_o;
   logic [IterBits-1:0]  iter_cnt_o;
   logic                 busy_o;
   logic                 err_o;

   modport slave (
      input  start_valid_i, sq_in_i, iters_i, abort_i, sq_valid_i, sq_result_i, out_ready_i,
      output start_ready_o, sq_start_o, sq_data_o, out_valid_o, sq_out_o, iter_cnt_o,
             busy_o, err_o
   );

   modport master (
      output start_valid_i, sq_in_i, iters_i, abort_i, sq_valid_i, sq_result_i, out_ready_i,
      input  start_ready_o, sq_start_o, sq_data_o, out_valid_o, sq_out_o, iter_cnt_o,
             busy_o, err_o
   );

endinterface

// File: rtl/msu_sq_sequencer.sv
// Repeated-squaring sequencer: computes x0^(2^T) by launching T squarings on an
// external datapath one at a time, with abort, drain and stray-result error tracking.
module msu_sq_sequencer #(
   parameter int unsigned TotalBits = 289,
   parameter int unsigned IterBits  = 64
) (
   input logic               clk,
   input logic               reset_n,
   msu_sq_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } stateE;

   stateE                stateQ,    stateNext;
   logic [TotalBits-1:0] valueQ,    valueNext;
   logic [IterBits-1:0]  targetQ,   targetNext;
   logic [IterBits-1:0]  iterCntQ,  iterCntNext;
   logic                 errQ,      errNext;

   // Datapath result is registered on entry, giving the L+2 launch-to-launch cadence.
   logic                 sqValidQ;
   logic [TotalBits-1:0] sqResultQ;

   logic [IterBits-1:0]  iterInc;
   logic                 strayValid;

   assign iterInc    = iterCntQ + IterBits'(1);
   assign strayValid = sqValidQ && ((stateQ == IDLE) || (stateQ == ISSUE) || (stateQ == DONE));

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stateQ    <= IDLE;
         valueQ    <= '0;
         targetQ   <= '0;
         iterCntQ  <= '0;
         errQ      <= 1'b0;
         sqValidQ  <= 1'b0;
         sqResultQ <= '0;
      end else begin
         stateQ    <= stateNext;
         valueQ    <= valueNext;
         targetQ   <= targetNext;
         iterCntQ  <= iterCntNext;
         errQ      <= errNext;
         sqValidQ  <= bus.sq_valid_i;
         sqResultQ <= bus.sq_result_i;
      end
   end

   // Next-state and register-update logic
   always_comb begin
      stateNext   = stateQ;
      valueNext   = valueQ;
      targetNext  = targetQ;
      iterCntNext = iterCntQ;
      errNext     = errQ;

      case (stateQ)
         IDLE: begin
            if (bus.start_valid_i) begin
               valueNext   = bus.sq_in_i;
               targetNext  = bus.iters_i;
               iterCntNext = '0;
               errNext     = 1'b0;
               stateNext   = (bus.iters_i == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            stateNext = bus.abort_i ? IDLE : WAIT;
         end
         WAIT: begin
            if (sqValidQ) begin
               if (bus.abort_i) begin
                  stateNext = IDLE;
               end else begin
                  valueNext   = sqResultQ;
                  iterCntNext = iterInc;
                  stateNext   = (iterInc == targetQ) ? DONE : ISSUE;
               end
            end else if (bus.abort_i) begin
               stateNext = DRAIN;
            end
         end
         DRAIN: begin
            if (sqValidQ) begin
               stateNext = IDLE;
            end
         end
         DONE: begin
            if (bus.out_ready_i) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      // A result with no launch outstanding is an error, even on an accept cycle.
      if (strayValid) begin
         errNext = 1'b1;
      end
   end

   // Outputs are decodes of registered state; the launch pulse is gated by abort.
   assign bus.start_ready_o = (stateQ == IDLE);
   assign bus.busy_o        = (stateQ != IDLE);
   assign bus.out_valid_o   = (stateQ == DONE);
   assign bus.sq_start_o    = (stateQ == ISSUE) && !bus.abort_i;
   assign bus.sq_data_o     = valueQ;
   assign bus.sq_out_o      = valueQ;
   assign bus.iter_cnt_o    = iterCntQ;
   assign bus.err_o         = errQ;

endmodule
